instr_queue: RTL and testbench

- Circular FIFO between fetch and the decode stage.
- Fetch pushes {pc, inst}. The queue stamps each accepted entry with a 64-bit RVFI order number.
- Decode pops one entry per cycle. The entry is returned one cycle later as a 128-bit word {order, pc, inst} with a pop_resp valid strobe.
- Supports a whole-queue flush on redirect, with the order counter reloaded.

---
 rtl/instr_queue.sv | 120 ++++++++++++
 tb/tb_instr_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: circular FIFO that stamps each
// accepted push with a wrapping order number and returns pops one cycle later.
module instr_queue #(
    parameter int DEPTH   = 16,
    parameter int ORDER_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [31:0]              push_inst,
    input  logic [31:0]              push_pc,
    output logic                     push_ready,
    input  logic                     instr_q_pop,
    output logic [127:0]             instr_data,
    output logic                     pop_resp,
    input  logic                     flush,
    input  logic [ORDER_W-1:0]       flush_order,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ORDER_W + 64;

    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic [ORDER_W-1:0] r_order;
    logic               r_pop_resp;
    logic [EW-1:0]      r_instr_data;

    logic               w_full;
    logic               w_empty;
    logic               w_push_acc;
    logic               w_pop_acc;
    logic [AW-1:0]      w_head_nxt;
    logic [AW-1:0]      w_tail_nxt;
    logic [CW-1:0]      w_count_nxt;
    logic [ORDER_W-1:0] w_order_nxt;
    logic               w_pop_resp_nxt;
    logic [EW-1:0]      w_instr_data_nxt;

    // Status flags come only from the registered count, so pop never reaches push_ready.
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == CW'(0));
    assign w_push_acc = push && !w_full && !flush;
    assign w_pop_acc  = instr_q_pop && !w_empty && !flush;

    assign full       = w_full;
    assign empty      = w_empty;
    assign push_ready = !w_full;
    assign count      = r_count;
    assign pop_resp   = r_pop_resp;
    assign instr_data = r_instr_data;

    // Next-state for pointers, occupancy, order counter and pop response.
    always_comb begin
        w_head_nxt       = r_head;
        w_tail_nxt       = r_tail;
        w_count_nxt      = r_count;
        w_order_nxt      = r_order;
        w_pop_resp_nxt   = 1'b0;
        w_instr_data_nxt = r_instr_data;
        if (flush) begin
            w_head_nxt  = AW'(0);
            w_tail_nxt  = AW'(0);
            w_count_nxt = CW'(0);
            w_order_nxt = flush_order;
        end else begin
            if (w_push_acc) begin
                w_tail_nxt  = r_tail + AW'(1);
                w_order_nxt = r_order + ORDER_W'(1);
            end else begin
                w_tail_nxt  = r_tail;
            end
            if (w_pop_acc) begin
                w_head_nxt       = r_head + AW'(1);
                w_instr_data_nxt = r_mem[r_head];
                w_pop_resp_nxt   = 1'b1;
            end else begin
                w_pop_resp_nxt   = 1'b0;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= AW'(0);
            r_tail       <= AW'(0);
            r_count      <= CW'(0);
            r_order      <= ORDER_W'(0);
            r_pop_resp   <= 1'b0;
            r_instr_data <= EW'(0);
        end else begin
            r_head       <= w_head_nxt;
            r_tail       <= w_tail_nxt;
            r_count      <= w_count_nxt;
            r_order      <= w_order_nxt;
            r_pop_resp   <= w_pop_resp_nxt;
            r_instr_data <= w_instr_data_nxt;
        end
    end

    // Entry storage; deliberately not reset and not cleared on flush.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_tail] <= {r_order, push_pc, push_inst};
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model compared
// every cycle, plus directed literal checks and randomized traffic.
module tb_instr_queue;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         push = 1'b0;
    logic [31:0]  push_inst = 32'd0;
    logic [31:0]  push_pc = 32'd0;
    logic         push_ready;
    logic         instr_q_pop = 1'b0;
    logic [127:0] instr_data;
    logic         pop_resp;
    logic         flush = 1'b0;
    logic [63:0]  flush_order = 64'd0;
    logic         full;
    logic         empty;
    logic [4:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] m_q[$];
    logic [63:0]  m_order = 64'd0;
    logic         m_resp = 1'b0;
    logic [127:0] m_data = 128'd0;

    instr_queue #(.DEPTH(DEPTH), .ORDER_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_inst(push_inst),
        .push_pc(push_pc), .push_ready(push_ready), .instr_q_pop(instr_q_pop),
        .instr_data(instr_data), .pop_resp(pop_resp), .flush(flush),
        .flush_order(flush_order), .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_order = 64'd0;
        m_resp  = 1'b0;
        m_data  = 128'd0;
    endfunction

    // Reference behaviour for one clock edge, from the pre-edge state and inputs.
    function automatic void model_edge();
        bit can_pop;
        bit can_push;
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_q.delete();
            m_order = flush_order;
            m_resp  = 1'b0;
        end else begin
            can_pop  = instr_q_pop && (m_q.size() != 0);
            can_push = push && (m_q.size() != DEPTH);
            m_resp   = can_pop;
            if (can_pop) m_data = m_q.pop_front();
            if (can_push) begin
                m_q.push_back({m_order, push_pc, push_inst});
                m_order = m_order + 64'd1;
            end
        end
    endfunction

    task automatic step(input logic p, input logic [31:0] pc, input logic [31:0] inst,
                        input logic pp, input logic fl, input logic [63:0] fo);
        @(negedge clk);
        push = p; push_pc = pc; push_inst = inst;
        instr_q_pop = pp; flush = fl; flush_order = fo;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("m_pop_resp", 128'(pop_resp), 128'(m_resp));
        chk("m_instr_data", instr_data, m_data);
        chk("m_count", 128'(count), 128'(m_q.size()));
        chk("m_full", 128'(full), 128'(m_q.size() == DEPTH));
        chk("m_empty", 128'(empty), 128'(m_q.size() == 0));
        chk("m_push_ready", 128'(push_ready), 128'(m_q.size() != DEPTH));
    end

    initial begin
        int pushed;
        int popped;
        int cyc;
        bit p;
        bit pp;
        bit p_ok;
        bit pp_ok;

        model_reset();
        @(posedge clk); #1;
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_full", 128'(full), 128'd0);
        chk("rst_push_ready", 128'(push_ready), 128'd1);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_data", instr_data, 128'd0);
        @(negedge clk); rst_n = 1'b1;

        // Three pushes then three pops.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1000 + 32'(4 * i), 32'h13, 1'b0, 1'b0, 64'd0);
        chk("t1_count", 128'(count), 128'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
            chk("t1_resp", 128'(pop_resp), 128'd1);
            chk("t1_data", instr_data, {64'(i), 32'h1000 + 32'(4 * i), 32'h13});
        end
        idle();
        chk("t1_resp_drop", 128'(pop_resp), 128'd0);
        chk("t1_empty", 128'(empty), 128'd1);

        // Fill to full, then a push dropped alongside a pop.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 64'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 32'h3000 + 32'(4 * i), 32'h33, 1'b0, 1'b0, 64'd0);
        chk("t2_count", 128'(count), 128'd16);
        chk("t2_full", 128'(full), 128'd1);
        chk("t2_ready", 128'(push_ready), 128'd0);
        step(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 64'd0);
        chk("t2_count15", 128'(count), 128'd15);
        chk("t2_order0", 128'(instr_data[127:64]), 128'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("t2_last_order", 128'(instr_data[127:64]), 128'd15);
        idle();
        chk("t2_empty", 128'(empty), 128'd1);

        // Interleaved traffic across pointer wrap.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 64'd0);
        pushed = 0; popped = 0; cyc = 0;
        while ((pushed < 40 || popped < 40) && cyc < 600) begin
            p  = (pushed < 40) && ($urandom_range(0, 2) != 0);
            pp = ($urandom_range(0, 1) == 1);
            p_ok  = p && (m_q.size() < DEPTH);
            pp_ok = pp && (m_q.size() > 0);
            step(p, 32'h2000 + 32'(4 * pushed), 32'h0000_0093, pp, 1'b0, 64'd0);
            if (p_ok) pushed++;
            if (pp_ok) begin
                chk("wrap_order", 128'(instr_data[127:64]), 128'(popped));
                chk("wrap_pc", 128'(instr_data[63:32]), 128'(32'h2000 + 32'(4 * popped)));
                popped++;
            end
            if (count > 5'd16) chk("wrap_count_max", 128'(count), 128'd16);
            cyc++;
        end
        if (cyc >= 600) chk("wrap_timeout", 128'(cyc), 128'd0);
        idle();
        chk("wrap_empty", 128'(empty), 128'd1);

        // Pop on empty and push+pop on empty: no bypass.
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("e_pop_resp", 128'(pop_resp), 128'd0);
        step(1'b1, 32'h4444, 32'h5555, 1'b1, 1'b0, 64'd0);
        chk("e_nobypass", 128'(pop_resp), 128'd0);
        chk("e_count1", 128'(count), 128'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("e_resp", 128'(pop_resp), 128'd1);
        chk("e_data", instr_data, {64'd40, 32'h4444, 32'h5555});

        // Flush with pending entries and a concurrent pop.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h5000 + 32'(4 * i), 32'h13, 1'b0, 1'b0, 64'd0);
        step(1'b1, 32'h9999, 32'h13, 1'b1, 1'b1, 64'd100);
        chk("f_resp", 128'(pop_resp), 128'd0);
        chk("f_count", 128'(count), 128'd0);
        chk("f_empty", 128'(empty), 128'd1);
        step(1'b1, 32'h6000, 32'h17, 1'b0, 1'b0, 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("f_order", instr_data, {64'd100, 32'h6000, 32'h17});

        // Order counter wraps at 2^64.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h7000 + 32'(4 * i), 32'h13, 1'b0, 1'b0, 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("ow_0", 128'(instr_data[127:64]), 128'(64'hFFFF_FFFF_FFFF_FFFE));
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("ow_1", 128'(instr_data[127:64]), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("ow_2", 128'(instr_data[127:64]), 128'd0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0)
                step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                     1'b1, {$urandom, $urandom});
            else
                step(1'($urandom_range(0, 99) < 55), $urandom, $urandom,
                     1'($urandom_range(0, 99) < 45), 1'b0, 64'd0);
        end

        // Asynchronous reset mid-stream.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 32'h8000 + 32'(4 * i), 32'h13, 1'b0, 1'b0, 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("ar_pre_count", 128'(count), 128'd7);
        chk("ar_pre_resp", 128'(pop_resp), 128'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_resp", 128'(pop_resp), 128'd0);
        chk("ar_data", instr_data, 128'd0);
        chk("ar_count", 128'(count), 128'd0);
        chk("ar_ready", 128'(push_ready), 128'd1);
        @(negedge clk); rst_n = 1'b1;
        step(1'b1, 32'hA000, 32'h13, 1'b0, 1'b0, 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0);
        chk("ar_first_order", instr_data, {64'd0, 32'hA000, 32'h13});
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
